// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        RST,
        FETCH,
        DROP
    } if_state_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Redirect targets are forced to a word boundary before they become the pc.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or flush it to an empty NOP slot.
import pipe_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    // An empty slot always reads as NOP so decode never sees a stale word.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            instr <= NOP_INSTR;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: pc, request FSM, and the IF/ID register feeding decode.
import pipe_pkg::*;

module if_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        bubble
);

    if_state_t   state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] pc_plus4;
    logic        load;
    logic        flush;

    assign pc_plus4 = pc + 32'd4;

    // Redirect beats stall; a missing response in FETCH becomes a bubble.
    always_comb begin
        load  = 1'b0;
        flush = 1'b0;
        if (redirect_valid) begin
            flush = 1'b1;
        end else if (!stall) begin
            case (state)
                FETCH:   begin load = imem_ready; flush = !imem_ready; end
                DROP:    flush = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RST;
            pc        <= RESET_PC;
            drop_addr <= 32'h0;
            imem_req  <= 1'b0;
        end else begin
            // Every state other than reset leads to FETCH or DROP, both of which request.
            imem_req <= 1'b1;
            case (state)
                RST: begin
                    state <= FETCH;
                    if (redirect_valid) pc <= word_align(redirect_pc);
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc <= word_align(redirect_pc);
                        if (!imem_ready) begin
                            state     <= DROP;
                            drop_addr <= pc;
                        end
                    end else if (!stall && imem_ready) begin
                        pc <= pc_plus4;
                    end
                end
                DROP: begin
                    // The abandoned request stays on the bus until memory answers it.
                    if (redirect_valid) pc <= word_align(redirect_pc);
                    if (imem_ready) state <= FETCH;
                end
                default: state <= RST;
            endcase
        end
    end

    assign imem_addr = (state == DROP) ? drop_addr : pc;

    if_id_reg u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .flush    (flush),
        .instr_in (imem_rdata),
        .pc4_in   (pc_plus4),
        .instr    (if_id_instr),
        .pc4      (if_id_pc4),
        .valid    (if_id_valid)
    );

    assign opcode = if_id_instr[31:26];
    assign funct  = if_id_instr[5:0];
    assign bubble = ~if_id_valid;

endmodule
